// File: rtl/dm_resp.sv
// dm_resp: multi-cycle data-memory responder for the MEM stage.
//
// This module models a slow word-addressed SRAM with a fixed access latency.
// It holds only one access in flight at a time. While that access is being
// serviced, 'stall' asks the pipeline to freeze.
//
// Ports
//   clk       system clock; all state updates happen on the rising edge
//   rst       synchronous, active-high reset
//   addr      word address from the MEM stage (only addr[IDX_W-1:0] is used)
//   re        read request
//   we        write request (takes priority when re is also high)
//   wrt_data  write data
//   rd_data   registered read data; holds until the next read commits
//   rd_vld    high for the single DONE cycle of a read
//   stall     combinational pipeline freeze: (IDLE & (re|we)) | BUSY
//
// Parameters
//   IDX_W     index bits taken from addr; the array holds 2**IDX_W words
//   LATENCY   number of BUSY cycles per access (1..15)

module dm_resp #(
    parameter int IDX_W   = 10,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic        re,
    input  logic        we,
    input  logic [15:0] wrt_data,
    output logic [15:0] rd_data,
    output logic        rd_vld,
    output logic        stall
);

    localparam int DEPTH = 1 << IDX_W;
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t stateCur;
    state_t stateNext;
    logic [3:0] cnt;
    logic [3:0] cntNext;

    logic [15:0] mem [0:DEPTH-1];

    // The request is latched at accept time. Inputs seen during BUSY or DONE
    // never reach the array.
    logic [IDX_W-1:0] reqIdx;
    logic [15:0]      reqData;
    logic             reqWrite;

    logic accept;
    logic commit;
    logic commitWrite;
    logic commitRead;

    // Address bits above IDX_W-1 alias onto the low words by design.
    logic unusedAddrBits;
    assign unusedAddrBits = ^addr;

    assign accept      = (stateCur == IDLE) && (re || we);
    assign commit      = (stateCur == BUSY) && (cnt == 4'd0);
    // A reset in the commit cycle discards the pending access.
    assign commitWrite = commit && reqWrite && !rst;
    assign commitRead  = commit && !reqWrite;

    assign stall  = accept || (stateCur == BUSY);
    assign rd_vld = (stateCur == DONE) && !reqWrite;

    // Next-state logic
    always_comb begin
        stateNext = stateCur;
        cntNext   = cnt;
        case (stateCur)
            IDLE: begin
                if (re || we) begin
                    stateNext = BUSY;
                    cntNext   = CNT_LOAD;
                end
            end
            BUSY: begin
                if (cnt == 4'd0) begin
                    stateNext = DONE;
                end else begin
                    cntNext = cnt - 4'd1;
                end
            end
            DONE: begin
                // The MEM stage still presents the same request in this
                // cycle, so it must not be re-accepted here.
                stateNext = IDLE;
            end
            default: begin
                stateNext = IDLE;
                cntNext   = 4'd0;
            end
        endcase
    end

    // Control and read-data register
    always_ff @(posedge clk) begin
        if (rst) begin
            stateCur <= IDLE;
            cnt      <= 4'd0;
            rd_data  <= 16'd0;
        end else begin
            stateCur <= stateNext;
            cnt      <= cntNext;
            if (commitRead) begin
                rd_data <= mem[reqIdx];
            end
        end
    end

    // Request latch and storage array (neither is reset)
    always_ff @(posedge clk) begin
        if (accept) begin
            reqIdx   <= addr[IDX_W-1:0];
            reqData  <= wrt_data;
            reqWrite <= we;
        end
        if (commitWrite) begin
            mem[reqIdx] <= reqData;
        end
    end

endmodule

// File: tb/tb_dm_resp.sv
// Testbench for dm_resp.
// Instance u2 uses LATENCY=2 and is driven from a cycle-by-cycle vector
// table, followed by a held-request sequence. Instance u1 uses LATENCY=1
// and is driven by a short hand-written sequence. Both instances share the
// clock and the reset.

module tb_dm_resp;

    logic        clk;
    logic        rst;

    logic [15:0] addr2, wdata2, rdData2;
    logic        re2, we2, rdVld2, stall2;

    logic [15:0] addr1, wdata1, rdData1;
    logic        re1, we1, rdVld1, stall1;

    int checks = 0;
    int errors = 0;

    dm_resp #(.IDX_W(10), .LATENCY(2)) u2 (
        .clk(clk), .rst(rst), .addr(addr2), .re(re2), .we(we2),
        .wrt_data(wdata2), .rd_data(rdData2), .rd_vld(rdVld2), .stall(stall2)
    );

    dm_resp #(.IDX_W(10), .LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .addr(addr1), .re(re1), .we(we1),
        .wrt_data(wdata1), .rd_data(rdData1), .rd_vld(rdVld1), .stall(stall1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        expStall;
        logic        expVld;
        logic        chkData;
        logic [15:0] expData;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic r, input logic rd, input logic wr,
                          input logic [15:0] a, input logic [15:0] d,
                          input logic s, input logic v,
                          input logic c, input logic [15:0] e);
        vec_t t;
        t.rst = r; t.re = rd; t.we = wr; t.addr = a; t.wdata = d;
        t.expStall = s; t.expVld = v; t.chkData = c; t.expData = e;
        vecs.push_back(t);
    endtask

    task automatic check(input string name, input logic [15:0] act,
                         input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    initial begin
        rst = 1'b1;
        re2 = 0; we2 = 0; addr2 = 0; wdata2 = 0;
        re1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;

        // Cycles 0-3: write 0xBEEF to 0x0010. Junk inputs are presented
        // during BUSY; rd_data stays at its reset value.
        addVec(0,0,1,16'h0010,16'hBEEF, 1,0,1,16'h0000);
        addVec(0,1,1,16'h0011,16'hDEAD, 1,0,0,16'h0000);
        addVec(0,1,1,16'h0011,16'hDEAD, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,0,1,16'h0000);
        // Cycles 4-7: read 0x0010.
        addVec(0,1,0,16'h0010,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,1,1,16'hBEEF);
        // Cycles 8-11: re and we together count as a write.
        addVec(0,1,1,16'h0020,16'h1234, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,0,1,16'hBEEF);
        // Cycles 12-15: read 0x0020.
        addVec(0,1,0,16'h0020,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,1,1,16'h1234);
        // Cycles 16-23: address wrap, write 0x0405 then read 0x0005.
        addVec(0,0,1,16'h0405,16'h0F0F, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,0,1,16'h1234);
        addVec(0,1,0,16'h0005,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,1,1,16'h0F0F);
        // Cycles 24-27: preload 0x0030 = 0x5555.
        addVec(0,0,1,16'h0030,16'h5555, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,0,1,16'h0F0F);
        // Cycles 28-31: write 0xAAAA, then reset in the second BUSY cycle.
        addVec(0,0,1,16'h0030,16'hAAAA, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(1,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,0,1,16'h0000);
        // Cycles 32-35: the aborted write left 0x5555 in place.
        addVec(0,1,0,16'h0030,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 1,0,0,16'h0000);
        addVec(0,0,0,16'h0000,16'h0000, 0,1,1,16'h5555);

        // Reset both instances.
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_stall2", {15'd0, stall2}, 16'd0);
        check("rst_vld2",   {15'd0, rdVld2}, 16'd0);
        check("rst_data2",  rdData2,         16'h0000);
        check("rst_stall1", {15'd0, stall1}, 16'd0);
        check("rst_data1",  rdData1,         16'h0000);

        // Table-driven vectors on u2.
        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; re2 = vecs[i].re; we2 = vecs[i].we;
            addr2 = vecs[i].addr; wdata2 = vecs[i].wdata;
            #1;
            check($sformatf("v%0d_stall", i), {15'd0, stall2}, {15'd0, vecs[i].expStall});
            check($sformatf("v%0d_vld", i),   {15'd0, rdVld2}, {15'd0, vecs[i].expVld});
            if (vecs[i].chkData)
                check($sformatf("v%0d_data", i), rdData2, vecs[i].expData);
        end

        // Held read of 0x0010 for three full accesses.
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            rst = 0; re2 = 1; we2 = 0; addr2 = 16'h0010; wdata2 = 16'h0000;
            #1;
            check($sformatf("held%0d_stall", c), {15'd0, stall2},
                  ((c % 4) == 3) ? 16'd0 : 16'd1);
            check($sformatf("held%0d_vld", c), {15'd0, rdVld2},
                  ((c % 4) == 3) ? 16'd1 : 16'd0);
            if ((c % 4) == 3)
                check($sformatf("held%0d_data", c), rdData2, 16'hBEEF);
        end
        @(negedge clk);
        re2 = 0;

        // LATENCY=1 on u1: write 0x7777 to 0x0007.
        @(negedge clk);
        we1 = 1; addr1 = 16'h0007; wdata1 = 16'h7777;
        #1 check("l1_w0_stall", {15'd0, stall1}, 16'd1);
        @(negedge clk);
        we1 = 0; addr1 = 16'h0000; wdata1 = 16'h0000;
        #1 check("l1_w1_stall", {15'd0, stall1}, 16'd1);
        @(negedge clk);
        #1 check("l1_w2_stall", {15'd0, stall1}, 16'd0);
        check("l1_w2_vld", {15'd0, rdVld1}, 16'd0);
        // Read it back: stall for two cycles, rd_vld in the third.
        @(negedge clk);
        re1 = 1; addr1 = 16'h0007;
        #1 check("l1_r0_stall", {15'd0, stall1}, 16'd1);
        check("l1_r0_vld", {15'd0, rdVld1}, 16'd0);
        @(negedge clk);
        re1 = 0; addr1 = 16'h0000;
        #1 check("l1_r1_stall", {15'd0, stall1}, 16'd1);
        check("l1_r1_vld", {15'd0, rdVld1}, 16'd0);
        @(negedge clk);
        #1 check("l1_r2_stall", {15'd0, stall1}, 16'd0);
        check("l1_r2_vld", {15'd0, rdVld1}, 16'd1);
        check("l1_r2_data", rdData1, 16'h7777);
        @(negedge clk);
        #1 check("l1_r3_vld", {15'd0, rdVld1}, 16'd0);
        check("l1_r3_data", rdData1, 16'h7777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
